// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Op codes, funct3 sizes, FSM states, latched control bundle, size_bytes().
package lsu_pkg;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic       wreg;
  } ctl_t;

  // D is only a real size on 64-bit datapaths.
  function automatic logic [3:0] size_bytes(
    input logic [2:0] f3,
    input logic       x64
  );
    logic [3:0] s;
    case (f3)
      F3_B, F3_BU: s = 4'd1;
      F3_H, F3_HU: s = 4'd2;
      F3_D:        s = x64 ? 4'd8 : 4'd4;
      default:     s = 4'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
// i_off/i_size/i_sdata -> lane selects and {hi,lo} write data; rdata pair -> extended load.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BYTES = XLEN / 8,
  parameter int OFF_W = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0] i_off,
  input  logic [3:0]       i_size,
  input  logic             i_uns,
  input  logic [XLEN-1:0]  i_sdata,
  input  logic [XLEN-1:0]  i_rdata0,
  input  logic [XLEN-1:0]  i_rdata1,
  output logic [BYTES-1:0] o_sel_lo,
  output logic [BYTES-1:0] o_sel_hi,
  output logic [XLEN-1:0]  o_wdata_lo,
  output logic [XLEN-1:0]  o_wdata_hi,
  output logic [XLEN-1:0]  o_ldata,
  output logic             o_cross
);

  int                  w_end;
  logic [2*BYTES-1:0]  w_mask;
  logic [2*XLEN-1:0]   w_simg;
  logic [2*XLEN-1:0]   w_rimg;
  logic                w_fill;

  always_comb begin
    w_end = int'(i_off) + int'(i_size);
    w_mask = '0;
    for (int i = 0; i < 2 * BYTES; i++) begin
      w_mask[i] = (i >= int'(i_off)) && (i < w_end);
    end
    o_cross = (w_end > BYTES);
    o_sel_lo = w_mask[BYTES-1:0];
    o_sel_hi = w_mask[2*BYTES-1:BYTES];

    w_simg = {{XLEN{1'b0}}, i_sdata} << {i_off, 3'b000};
    o_wdata_lo = w_simg[XLEN-1:0];
    o_wdata_hi = w_simg[2*XLEN-1:XLEN];

    // Second word only matters when the access crosses.
    w_rimg = {i_rdata1, i_rdata0} >> {i_off, 3'b000};
    unique case (1'b1)
      i_size[0]: w_fill = w_rimg[7];
      i_size[1]: w_fill = w_rimg[15];
      default:   w_fill = w_rimg[31];
    endcase
    w_fill = w_fill & ~i_uns;

    o_ldata = '0;
    for (int i = 0; i < XLEN; i++) begin
      o_ldata[i] = (i < int'(i_size) * 8) ? w_rimg[i] : w_fill;
    end
  end

endmodule

// File: rtl/lsu_access_unit.sv
// MEM-stage load/store unit: one op per EX handshake, split misaligned bus access, WB result.
// Ports: clk/rst, in_* from EX, mem_* data bus (req/ready), out_* to WB.
module lsu_access_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [4:0]        in_rd,
  input  logic              in_wreg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [4:0]        out_rd,
  output logic              out_wreg,
  output logic [XLEN-1:0]   out_data,
  output logic              out_misalign
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic [1:0]        r_state;
  ctl_t              r_ctl;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_sdata;
  logic [XLEN-1:0]   r_rdata0;

  logic              w_idle;
  logic              w_acc0;
  logic              w_accept;
  logic              w_is_mem;
  logic [2:0]        w_f3;
  logic [ADDR_W-1:0] w_addr;
  logic [XLEN-1:0]   w_sdata;
  logic [3:0]        w_size;
  logic [ADDR_W-1:0] w_word;
  logic [XLEN-1:0]   w_rdata0;
  logic              w_done;
  logic              w_cross;
  logic              w_fault;
  logic              w_split;
  logic [BYTES-1:0]  w_sel_lo;
  logic [BYTES-1:0]  w_sel_hi;
  logic [XLEN-1:0]   w_wd_lo;
  logic [XLEN-1:0]   w_wd_hi;
  logic [XLEN-1:0]   w_ld;

  assign w_idle   = (r_state == S_IDLE);
  assign w_acc0   = (r_state == S_ACC0);
  assign in_ready = w_idle;
  assign w_accept = in_valid & w_idle;
  assign w_is_mem = (in_op == OP_LOAD) | (in_op == OP_STORE);

  // Aligner sees the incoming op in IDLE, the latched op afterwards.
  assign w_f3    = w_idle ? in_funct3 : r_ctl.f3;
  assign w_addr  = w_idle ? in_addr : r_addr;
  assign w_sdata = w_idle ? in_sdata : r_sdata;
  assign w_size  = size_bytes(w_f3, XLEN == 64);
  assign w_word  = {w_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // In ACC1 the first word comes from the capture register.
  assign w_rdata0 = w_acc0 ? mem_rdata : r_rdata0;
  assign w_done   = mem_req & mem_ready;
  assign w_fault  = (MISALIGN_EN == 0) & w_cross;
  assign w_split  = (MISALIGN_EN != 0) & w_cross;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_off      (w_addr[OFF_W-1:0]),
    .i_size     (w_size),
    .i_uns      (w_f3[2]),
    .i_sdata    (w_sdata),
    .i_rdata0   (w_rdata0),
    .i_rdata1   (mem_rdata),
    .o_sel_lo   (w_sel_lo),
    .o_sel_hi   (w_sel_hi),
    .o_wdata_lo (w_wd_lo),
    .o_wdata_hi (w_wd_hi),
    .o_ldata    (w_ld),
    .o_cross    (w_cross)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ctl        <= '0;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_rdata0     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_sel      <= '0;
      mem_wdata    <= '0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_wreg     <= 1'b0;
      out_data     <= '0;
      out_misalign <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_misalign <= 1'b0;
      unique case (1'b1)
        w_idle: begin
          if (w_accept) begin
            r_ctl   <= '{op: in_op, f3: in_funct3, wreg: in_wreg};
            r_addr  <= in_addr;
            r_sdata <= in_sdata;
            out_rd  <= in_rd;
            if (!w_is_mem) begin
              out_valid <= 1'b1;
              out_data  <= in_alu;
              out_wreg  <= in_wreg;
            end else if (w_fault) begin
              out_valid    <= 1'b1;
              out_misalign <= 1'b1;
              out_wreg     <= 1'b0;
              out_data     <= '0;
            end else begin
              r_state   <= S_ACC0;
              mem_req   <= 1'b1;
              mem_we    <= (in_op == OP_STORE);
              mem_addr  <= w_word;
              mem_sel   <= w_sel_lo;
              mem_wdata <= w_wd_lo;
            end
          end
        end
        default: begin
          if (w_done) begin
            if (w_acc0 && w_split) begin
              // Keep mem_req high straight into the second word.
              r_state   <= S_ACC1;
              r_rdata0  <= mem_rdata;
              mem_addr  <= mem_addr + ADDR_W'(BYTES);
              mem_sel   <= w_sel_hi;
              mem_wdata <= w_wd_hi;
            end else begin
              r_state   <= S_IDLE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              out_valid <= 1'b1;
              out_wreg  <= (r_ctl.op == OP_LOAD) & r_ctl.wreg;
              out_data  <= (r_ctl.op == OP_LOAD) ? w_ld : '0;
            end
          end
        end
      endcase
    end
  end

endmodule
